// File: rtl/sigma_sum_accumulator.sv
// rtl/sigma_sum_accumulator.sv - per-frame sum of squared residuals and correspondence count
package RgbdVoConfigPk;
    localparam int DATA_RGB_BW = 4;
    localparam int H_SIZE_BW   = 3;
    localparam int V_SIZE_BW   = 3;
endpackage

module sigma_sum_accumulator
    import RgbdVoConfigPk::*;
#(
    parameter  int RES_BW = DATA_RGB_BW + 1,
    localparam int SUM_BW = H_SIZE_BW + V_SIZE_BW + 2 * DATA_RGB_BW + 2,
    localparam int CNT_BW = H_SIZE_BW + V_SIZE_BW
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_frame_start,
    input  logic                     i_frame_end,
    input  logic                     i_valid,
    input  logic                     i_corresp,
    input  logic signed [RES_BW-1:0] i_residual,
    output logic                     o_frame_end,
    output logic [SUM_BW-1:0]        o_sigma_s_rgbd,
    output logic [CNT_BW-1:0]        o_corresp_count
);

    localparam int SQ_BW = 2 * RES_BW;
    localparam logic [SUM_BW-1:0] SUM_MAX = {1'b0, {(SUM_BW-1){1'b1}}};
    localparam logic [CNT_BW-1:0] CNT_MAX = {CNT_BW{1'b1}};
    localparam logic [CNT_BW-1:0] CNT_ONE = {{(CNT_BW-1){1'b0}}, 1'b1};

    // Stage d1
    logic [SQ_BW-1:0]  sq_q, sq_d;
    logic              accept_q, accept_d;
    logic              start_q, start_d;
    logic              end1_q, end1_d;
    // Stage d2 and output totals
    logic [SUM_BW-1:0] acc_sum_q, acc_sum_d;
    logic [CNT_BW-1:0] acc_cnt_q, acc_cnt_d;
    logic              end2_q, end2_d;
    logic [SUM_BW-1:0] out_sum_q, out_sum_d;
    logic [CNT_BW-1:0] out_cnt_q, out_cnt_d;

    logic signed [SQ_BW-1:0] res_ext;
    logic signed [SQ_BW-1:0] sq_s;
    logic [SUM_BW-1:0]       sq_ext;
    logic [SUM_BW:0]         sum_ext;

    // Sign-extend before squaring so the most-negative residual squares exactly.
    always_comb begin
        res_ext  = {{RES_BW{i_residual[RES_BW-1]}}, i_residual};
        sq_s     = res_ext * res_ext;
        sq_d     = $unsigned(sq_s);
        accept_d = i_valid && i_corresp;
        start_d  = i_frame_start;
        end1_d   = i_frame_end;
    end

    always_comb begin
        sq_ext    = {{(SUM_BW-SQ_BW){1'b0}}, sq_q};
        sum_ext   = {1'b0, acc_sum_q} + {1'b0, sq_ext};
        acc_sum_d = acc_sum_q;
        acc_cnt_d = acc_cnt_q;
        if (start_q) begin
            acc_sum_d = accept_q ? sq_ext : '0;
            acc_cnt_d = accept_q ? CNT_ONE : '0;
        end else if (accept_q) begin
            acc_sum_d = (sum_ext > {1'b0, SUM_MAX}) ? SUM_MAX : sum_ext[SUM_BW-1:0];
            acc_cnt_d = (acc_cnt_q == CNT_MAX) ? CNT_MAX : acc_cnt_q + CNT_ONE;
        end
        // Totals capture the post-update accumulator so the last pixel is included.
        end2_d    = end1_q;
        out_sum_d = end1_q ? acc_sum_d : out_sum_q;
        out_cnt_d = end1_q ? acc_cnt_d : out_cnt_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sq_q      <= '0;
            accept_q  <= 1'b0;
            start_q   <= 1'b0;
            end1_q    <= 1'b0;
            acc_sum_q <= '0;
            acc_cnt_q <= '0;
            end2_q    <= 1'b0;
            out_sum_q <= '0;
            out_cnt_q <= '0;
        end else begin
            sq_q      <= sq_d;
            accept_q  <= accept_d;
            start_q   <= start_d;
            end1_q    <= end1_d;
            acc_sum_q <= acc_sum_d;
            acc_cnt_q <= acc_cnt_d;
            end2_q    <= end2_d;
            out_sum_q <= out_sum_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    assign o_frame_end     = end2_q;
    assign o_sigma_s_rgbd  = out_sum_q;
    assign o_corresp_count = out_cnt_q;

endmodule

// File: tb/tb_sigma_sum_accumulator.sv
// tb/tb_sigma_sum_accumulator.sv - directed self-checking bench for sigma_sum_accumulator
module tb_sigma_sum_accumulator;
    import RgbdVoConfigPk::*;

    localparam int RES_BW = DATA_RGB_BW + 1;
    localparam int SUM_BW = H_SIZE_BW + V_SIZE_BW + 2 * DATA_RGB_BW + 2;
    localparam int CNT_BW = H_SIZE_BW + V_SIZE_BW;

    logic                     i_clk = 1'b0;
    logic                     i_rst_n = 1'b0;
    logic                     i_frame_start = 1'b0;
    logic                     i_frame_end = 1'b0;
    logic                     i_valid = 1'b0;
    logic                     i_corresp = 1'b0;
    logic signed [RES_BW-1:0] i_residual = '0;
    logic                     o_frame_end;
    logic [SUM_BW-1:0]        o_sigma_s_rgbd;
    logic [CNT_BW-1:0]        o_corresp_count;

    int total = 0;
    int bad   = 0;

    sigma_sum_accumulator dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_frame_start  (i_frame_start),
        .i_frame_end    (i_frame_end),
        .i_valid        (i_valid),
        .i_corresp      (i_corresp),
        .i_residual     (i_residual),
        .o_frame_end    (o_frame_end),
        .o_sigma_s_rgbd (o_sigma_s_rgbd),
        .o_corresp_count(o_corresp_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic fe, input int sum, input int cnt);
        chk({tag, "_fe"}, 32'(o_frame_end), 32'(fe));
        chk({tag, "_sum"}, 32'(o_sigma_s_rgbd), 32'(sum));
        chk({tag, "_cnt"}, 32'(o_corresp_count), 32'(cnt));
    endtask

    // One pixel slot: inputs change 1 time unit after a rising edge, sampled on the next.
    task automatic drive(input logic s, input logic e, input logic v, input logic c, input int r);
        i_frame_start = s;
        i_frame_end   = e;
        i_valid       = v;
        i_corresp     = c;
        i_residual    = RES_BW'(r);
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        logic spurious;
        repeat (3) @(posedge i_clk);
        #1;
        chk_out("reset", 1'b0, 0, 0);
        i_rst_n = 1'b1;
        idle();

        // End with no start since reset reports the cleared accumulator.
        drive(0, 1, 0, 0, 0);
        idle();
        chk_out("end_no_start", 1'b1, 0, 0);

        // {3,-4,0,5}: 9+16+0+25
        drive(1, 0, 1, 1, 3);
        drive(0, 0, 1, 1, -4);
        drive(0, 0, 1, 1, 0);
        drive(0, 1, 1, 1, 5);
        chk("basic_fe_early", 32'(o_frame_end), 32'd0);
        idle();
        chk_out("basic", 1'b1, 50, 4);

        // -4 lacks correspondence, one invalid slot: 9+0+25
        drive(1, 0, 1, 1, 3);
        drive(0, 0, 1, 0, -4);
        drive(0, 0, 0, 1, 7);
        drive(0, 0, 1, 1, 0);
        drive(0, 1, 1, 1, 5);
        idle();
        chk_out("masked", 1'b1, 34, 3);
        idle();
        chk_out("masked_hold", 1'b0, 34, 3);
        drive(1, 0, 1, 1, 1);
        chk_out("hold_next_a", 1'b0, 34, 3);
        drive(0, 1, 1, 1, 2);
        chk_out("hold_next_b", 1'b0, 34, 3);
        idle();
        chk_out("next_frame", 1'b1, 5, 2);

        // Back-to-back frames: A={2,3}, B={4,-1}
        drive(1, 0, 1, 1, 2);
        drive(0, 1, 1, 1, 3);
        drive(1, 0, 1, 1, 4);
        chk_out("b2b_a", 1'b1, 13, 2);
        drive(0, 1, 1, 1, -1);
        chk_out("b2b_hold", 1'b0, 13, 2);
        idle();
        chk_out("b2b_b", 1'b1, 17, 2);

        // Single-slot frames, most-negative residual then a rejected slot
        drive(1, 1, 1, 1, -16);
        idle();
        chk_out("single_neg", 1'b1, 256, 1);
        drive(1, 1, 1, 0, 5);
        idle();
        chk_out("single_rej", 1'b1, 0, 0);

        // Restart mid-frame discards the partial sum: only {1,2} count
        drive(1, 0, 1, 1, 5);
        drive(0, 0, 1, 1, 5);
        drive(1, 0, 1, 1, 1);
        drive(0, 1, 1, 1, 2);
        idle();
        chk_out("restart", 1'b1, 5, 2);

        // Saturation: 130 x 256 exceeds 32767, then 16 x max positive residual
        drive(1, 0, 1, 1, -16);
        for (int i = 0; i < 129; i++) drive(0, 0, 1, 1, -16);
        for (int i = 0; i < 15; i++) drive(0, 0, 1, 1, 15);
        drive(0, 1, 1, 1, 15);
        idle();
        chk_out("saturate", 1'b1, 32767, 63);
        chk("saturate_msb", 32'(o_sigma_s_rgbd[SUM_BW-1]), 32'd0);

        // Reset mid-frame with a frame_end already in the pipeline
        drive(1, 0, 1, 1, 1);
        drive(0, 0, 1, 1, 1);
        drive(0, 0, 1, 1, 1);
        drive(0, 1, 1, 1, 1);
        idle();
        i_rst_n = 1'b0;
        #2;
        chk_out("async_reset", 1'b0, 0, 0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        spurious = 1'b0;
        for (int i = 0; i < 5; i++) begin
            idle();
            spurious = spurious | o_frame_end;
        end
        chk("no_spurious_fe", 32'(spurious), 32'd0);
        drive(1, 0, 1, 1, 1);
        drive(0, 1, 1, 1, 1);
        idle();
        chk_out("post_reset", 1'b1, 2, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
